// File: rtl/tx_redundant_framer.sv
// Redundant UDP-style frame transmitter: sends a burst of identical frames (header + payload)
// separated by IFG idle cycles, stamping each copy with its index.
module tx_redundant_framer #(
  parameter logic [47:0] ETH_DST_MAC = 48'hDEADBEEF0123,
  parameter logic [47:0] ETH_SRC_MAC = 48'h000A35000102,
  parameter logic [31:0] IP_SRC_ADDR = 32'hC0A80140,
  parameter int          PAYLOAD_LEN = 1024,
  parameter int          IFG         = 12
) (
  input  logic        clk125MHz,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] segment_num,
  input  logic [7:0]  aux,
  input  logic [7:0]  redundancy,
  output logic [10:0] pl_addr,
  output logic        pl_rd,
  input  logic [7:0]  pl_data,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, HDR, PAY, GAP} state_t;

  localparam int            BW       = 12;
  localparam logic [BW-1:0] HDR_LAST = BW'(37);
  localparam logic [BW-1:0] RD_FIRST = BW'(37);
  localparam logic [BW-1:0] RD_LAST  = BW'(36 + PAYLOAD_LEN);
  localparam logic [BW-1:0] PAY_LAST = BW'(37 + PAYLOAD_LEN);
  localparam logic [BW-1:0] GAP_LAST = BW'(IFG - 1);

  state_t        state;
  logic [BW-1:0] bidx;     // byte index in HDR/PAY, idle count in GAP
  logic [BW-1:0] nb;
  logic [15:0]   seg_q;
  logic [7:0]    aux_q, red_q, copy_q, tx_q, hdr_next;
  logic          pay_sel, rd_next;
  logic [303:0]  hdr_vec;

  assign nb = bidx + BW'(1);

  assign hdr_vec = {48'h555555555555, ETH_DST_MAC, ETH_SRC_MAC, 16'h0800, 48'h0,
                    IP_SRC_ADDR, 16'h0000, 8'h01, 8'h02, seg_q, copy_q, aux_q};

  always_comb begin
    hdr_next = 8'h00;
    if (nb <= HDR_LAST)
      hdr_next = hdr_vec[8*(37 - int'(nb[5:0])) +: 8];
  end

  // Reads run one cycle ahead so the synchronous buffer data lands on its byte slot.
  assign rd_next = (state == HDR || state == PAY) && nb >= RD_FIRST && nb <= RD_LAST;

  always_ff @(posedge clk125MHz) begin
    if (reset) begin
      state   <= IDLE;
      bidx    <= '0;
      seg_q   <= '0;
      aux_q   <= '0;
      red_q   <= '0;
      copy_q  <= '0;
      tx_q    <= '0;
      tx_en   <= 1'b0;
      pay_sel <= 1'b0;
      pl_rd   <= 1'b0;
      pl_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done    <= 1'b0;
      pl_rd   <= rd_next;
      pl_addr <= rd_next ? 11'(nb - RD_FIRST) : '0;
      case (state)
        IDLE: if (start) begin
          seg_q  <= segment_num;
          aux_q  <= aux;
          red_q  <= (redundancy == 8'd0) ? 8'd1 : redundancy;
          copy_q <= '0;
          state  <= HDR;
          busy   <= 1'b1;
          tx_en  <= 1'b1;
          tx_q   <= 8'h55;
          bidx   <= '0;
        end
        HDR: begin
          bidx <= nb;
          if (bidx == HDR_LAST) begin
            state   <= PAY;
            pay_sel <= 1'b1;
            tx_q    <= 8'h00;
          end else begin
            tx_q <= hdr_next;
          end
        end
        PAY: begin
          if (bidx == PAY_LAST) begin
            state   <= GAP;
            tx_en   <= 1'b0;
            pay_sel <= 1'b0;
            bidx    <= '0;
          end else begin
            bidx <= nb;
          end
        end
        GAP: begin
          if (bidx == GAP_LAST) begin
            if ({1'b0, copy_q} + 9'd1 < {1'b0, red_q}) begin
              copy_q <= copy_q + 8'd1;
              state  <= HDR;
              tx_en  <= 1'b1;
              tx_q   <= 8'h55;
              bidx   <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            bidx <= nb;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tx_data = pay_sel ? pl_data : tx_q;

endmodule

// File: tb/tb_tx_redundant_framer.sv
// Bench for tx_redundant_framer: expected frame streams are built from the header layout and
// a payload buffer model, then compared cycle by cycle.
module tb_tx_redundant_framer;
  localparam int PL  = 16;
  localparam int IFG = 12;
  localparam int FL  = 38 + PL;
  localparam logic [47:0] DST = 48'hDEADBEEF0123;
  localparam logic [47:0] SRC = 48'h000A35000102;
  localparam logic [31:0] IPA = 32'hC0A80140;

  logic        clk125MHz = 1'b0;
  logic        reset, start;
  logic [15:0] segment_num;
  logic [7:0]  aux, redundancy;
  logic [10:0] pl_addr;
  logic        pl_rd;
  logic [7:0]  pl_data = 8'h00;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        busy, done;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] mem [0:2047];
  logic [7:0] rx  [0:7][0:PL-1];
  logic [7:0] rx_cp [0:7];

  tx_redundant_framer #(.PAYLOAD_LEN(PL), .IFG(IFG)) dut (
    .clk125MHz(clk125MHz), .reset(reset), .start(start), .segment_num(segment_num),
    .aux(aux), .redundancy(redundancy), .pl_addr(pl_addr), .pl_rd(pl_rd),
    .pl_data(pl_data), .tx_en(tx_en), .tx_data(tx_data), .busy(busy), .done(done));

  always #4 clk125MHz = ~clk125MHz;

  always @(posedge clk125MHz) if (pl_rd) pl_data <= mem[pl_addr];

  task automatic fill_mem(input bit ramp);
    for (int k = 0; k < 2048; k++) mem[k] = ramp ? 8'(k) : 8'($urandom);
  endtask

  task automatic check_idle(input string tag);
    n_chk++;
    if ({tx_en, tx_data, pl_rd, busy, done} !== 12'h0) begin
      n_fail++;
      $display("FAIL %s: en=%b data=%h rd=%b busy=%b done=%b, required all zero",
               tag, tx_en, tx_data, pl_rd, busy, done);
    end
  endtask

  // Issues one start, then checks every cycle of the burst against the frame model.
  task automatic run_burst(input logic [15:0] seg, input logic [7:0] ax, input logic [7:0] red,
                           input bit disturb, input string tag);
    int nf, total;
    nf = (red == 8'd0) ? 1 : int'(red);
    total = nf * (FL + IFG) + 1;
    @(negedge clk125MHz);
    start = 1'b1; segment_num = seg; aux = ax; redundancy = red;
    @(negedge clk125MHz);
    start = 1'b0;
    segment_num = 16'($urandom); aux = 8'($urandom); redundancy = 8'($urandom);
    for (int j = 0; j < total; j++) begin
      int f, p;
      logic [303:0] hdr;
      logic [11:0] exp_v, got_v;
      logic e_rd;
      logic [10:0] e_addr;
      f = j / (FL + IFG);
      p = j % (FL + IFG);
      hdr = {48'h555555555555, DST, SRC, 16'h0800, 48'h0, IPA, 16'h0000, 8'h01, 8'h02,
             seg, 8'(f), ax};
      e_rd = 1'b0;
      e_addr = 11'(p - 37);
      if (j == total - 1)
        exp_v = {1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
      else if (p < FL) begin
        e_rd = (p >= 37) && (p <= 36 + PL);
        exp_v = {1'b1, (p < 38) ? hdr[8*(37-p) +: 8] : mem[p-38], e_rd, 1'b1, 1'b0};
      end else
        exp_v = {1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
      got_v = {tx_en, tx_data, pl_rd, busy, done};
      n_chk++;
      if (got_v !== exp_v || (e_rd && pl_addr !== e_addr)) begin
        n_fail++;
        $display("FAIL %s cyc %0d (copy %0d i=%0d): en/data/rd/busy/done=%h addr=%0d, required %h addr=%0d",
                 tag, j, f, p, got_v, pl_addr, exp_v, e_addr);
      end
      if (j < total - 1 && p < FL && f < 8) begin
        if (p == 36) rx_cp[f] = tx_data;
        if (p >= 38) rx[f][p-38] = tx_data;
      end
      start = 1'b0;
      if (disturb && (j == 5 || j == 45 || j == 60 || j == FL + IFG + 20)) begin
        start = 1'b1; segment_num = 16'($urandom); aux = 8'($urandom);
        redundancy = 8'($urandom);
      end
      @(negedge clk125MHz);
    end
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_idle({tag, " post-burst idle"});
      @(negedge clk125MHz);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; segment_num = '0; aux = '0; redundancy = '0;
    repeat (2) @(negedge clk125MHz);
    check_idle("reset state");
    n_chk++;
    if (pl_addr !== 11'd0) begin
      n_fail++; $display("FAIL reset pl_addr: got %0d, required 0", pl_addr);
    end
    start = 1'b1; redundancy = 8'd2;
    @(negedge clk125MHz);
    start = 1'b0; reset = 1'b0;
    @(negedge clk125MHz);
    check_idle("reset beats start");
  endtask

  task automatic test_triple_burst();
    fill_mem(1'b1);
    run_burst(16'h0102, 8'hA5, 8'd3, 1'b0, "triple");
  endtask

  task automatic test_redundancy_zero();
    fill_mem(1'b0);
    run_burst(16'($urandom), 8'($urandom), 8'd0, 1'b0, "red0");
  endtask

  task automatic test_start_ignored();
    fill_mem(1'b0);
    run_burst(16'hBEEF, 8'h3C, 8'd2, 1'b1, "start ignored");
  endtask

  task automatic test_loopback();
    logic [7:0] maj;
    fill_mem(1'b0);
    run_burst(16'h7001, 8'h11, 8'd3, 1'b0, "loopback");
    for (int c = 0; c < 3; c++) begin
      n_chk++;
      if (rx_cp[c] !== 8'(c)) begin
        n_fail++; $display("FAIL loopback copy idx %0d: got %h, required %h", c, rx_cp[c], 8'(c));
      end
    end
    for (int k = 0; k < PL; k++) begin
      maj = (rx[0][k] & rx[1][k]) | (rx[0][k] & rx[2][k]) | (rx[1][k] & rx[2][k]);
      n_chk++;
      if (maj !== mem[k]) begin
        n_fail++; $display("FAIL loopback vote byte %0d: got %h, required %h", k, maj, mem[k]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    fill_mem(1'b0);
    @(negedge clk125MHz);
    start = 1'b1; segment_num = 16'h0A0B; aux = 8'h5A; redundancy = 8'd3;
    @(negedge clk125MHz);
    start = 1'b0;
    repeat (FL + IFG + 40) @(negedge clk125MHz);
    n_chk++;
    if (tx_en !== 1'b1 || tx_data !== mem[2]) begin
      n_fail++; $display("FAIL midframe byte 40: en=%b data=%h, required 1 %h", tx_en, tx_data, mem[2]);
    end
    reset = 1'b1;
    @(negedge clk125MHz);
    check_idle("reset midframe");
    n_chk++;
    if (pl_addr !== 11'd0) begin
      n_fail++; $display("FAIL midframe pl_addr: got %0d, required 0", pl_addr);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk125MHz);
    check_idle("after midframe reset");
    run_burst(16'h0C0D, 8'h77, 8'd2, 1'b0, "fresh after reset");
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      fill_mem(1'b0);
      run_burst(16'($urandom), 8'($urandom), 8'($urandom_range(1, 4)), 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_triple_burst();
    test_redundancy_zero();
    test_start_ignored();
    test_loopback();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_redundant_framer.md
TX_REDUNDANT_FRAMER -- requirements
Module: tx_redundant_framer

Interface
REQ-001 Parameters (name, default, meaning):
- ETH_DST_MAC, 48'hDEADBEEF0123, destination MAC
- ETH_SRC_MAC, 48'h000A35000102, source MAC
- IP_SRC_ADDR, 32'hC0A80140, source IP
- PAYLOAD_LEN, 1024, payload bytes per frame, 1..2047
- IFG, 12, idle cycles after each frame, 1..255
REQ-002 Ports (name, direction, width, meaning):
- clk125MHz, in, 1, sole clock
- reset, in, 1, synchronous, active-high
- start, in, 1, request one frame burst
- segment_num, in, 16, segment number to send
- aux, in, 8, auxiliary byte to send
- redundancy, in, 8, copies per burst
- pl_addr, out, 11, payload buffer read address
- pl_rd, out, 1, payload read strobe
- pl_data, in, 8, payload byte, valid exactly 1 cycle after pl_rd
- tx_en, out, 1, byte valid
- tx_data, out, 8, frame byte
- busy, out, 1, burst in progress
- done, out, 1, one-cycle pulse at burst end

Function
REQ-003 States SHALL be IDLE, HDR, PAY, GAP; all transitions on rising clk125MHz.
REQ-004 In IDLE with start=1, the block SHALL latch segment_num, aux, and redundancy (0 treated as 1), clear copy index to 0, and enter HDR next cycle; busy=1 from that cycle.
REQ-005 start SHALL be ignored while busy=1.
REQ-006 Byte index i counts from 0 at the first tx_en=1 cycle of each frame; tx_en SHALL stay 1 for exactly 38+PAYLOAD_LEN consecutive cycles.
REQ-007 Header layout:
- i 0-5: 0x55
- i 6-11: ETH_DST_MAC, MSB first
- i 12-17: ETH_SRC_MAC
- i 18-19: 0x08,0x00
- i 20-25: 0x00
- i 26-29: IP_SRC_ADDR, MSB first
- i 30-31: 0x00
- i 32: 0x01
- i 33: 0x02
- i 34: latched segment_num[15:8]
- i 35: latched segment_num[7:0]
- i 36: copy index (0..redundancy-1)
- i 37: latched aux
REQ-008 HDR SHALL last 38 cycles, then enter PAY.
REQ-009 PAY SHALL emit pl_data for buffer addresses 0..PAYLOAD_LEN-1 at i=38..37+PAYLOAD_LEN, without gaps.
REQ-010 pl_rd=1 with pl_addr=k SHALL occur exactly one cycle before byte i=38+k is on tx_data, i.e. first read at i=37 and last at i=36+PAYLOAD_LEN; pl_rd=0 otherwise.
REQ-011 Every copy SHALL re-read the full payload from address 0; payload bytes are identical across copies if the buffer is unchanged.
REQ-012 After the last payload byte the block SHALL enter GAP: tx_en=0 and tx_data=0x00 for exactly IFG cycles.
REQ-013 GAP exit: if copy index+1 < latched redundancy, increment copy index and enter HDR; else enter IDLE.
REQ-014 On GAP exit to IDLE: done=1 for one cycle and busy=0 in that same cycle.
REQ-015 Whenever tx_en=0, tx_data SHALL be 0x00.
REQ-016 Byte index and payload address counters SHALL NOT wrap within a frame; internal byte counter width SHALL be at least 12 bits.
REQ-017 Changes to segment_num, aux, or redundancy during a burst SHALL NOT affect that burst.

Reset
REQ-018 reset=1 SHALL, on the next edge and regardless of state (including mid-frame), force:
- state IDLE
- tx_en=0, tx_data=0x00
- pl_rd=0, pl_addr=0
- busy=0, done=0
- copy index 0
REQ-019 reset SHALL take priority over start in the same cycle.

Verification
REQ-020 Bench SHALL cover:
- PAYLOAD_LEN=16, buffer byte k=k, start with segment_num=0x0102, aux=0xA5, redundancy=3 -> three 54-byte frames, bytes 34-37 = 01,02,{00,01,02},A5; payload 00..0F each; 12 idle cycles between/after frames; single done pulse.
- redundancy=0 -> exactly one frame with byte 36=0x00.
- start pulses during HDR, PAY, and GAP -> no extra frames; latched fields unchanged.
- pl_rd/pl_addr trace -> addr 0 at i=37, addr 15 at i=52, no other reads.
- reset asserted at i=40 of copy 1 -> tx_en=0, busy=0 next cycle; a later start sends a full fresh burst from copy 0.
- Loopback into the team's majority-vote receiver with redundancy=3 -> frames pass validation; recovered payload equals buffer contents.
